// File: rtl/ideal_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// ideal_pulse_gen_if
// Request channel into the pulse generator. Each request carries a target
// time {utc, coarse} on the shared timebase, a fine-delay setting that is
// passed through to the delay line, and a pulse width in reference cycles.
//   valid  : request present (master -> slave)
//   ready  : request queue can accept (slave -> master)
//   utc    : target seconds
//   coarse : target coarse cycle within the second
//   frac   : fine-delay setting, passed through untouched
//   width  : pulse length in reference cycles (0 behaves as 1)
// ---------------------------------------------------------------------------
interface ideal_pulse_gen_if;
    logic        valid;
    logic        ready;
    logic [31:0] utc;
    logic [27:0] coarse;
    logic [22:0] frac;
    logic [27:0] width;

    modport master (output valid, utc, coarse, frac, width, input ready);
    modport slave  (input valid, utc, coarse, frac, width, output ready);
endinterface

// File: rtl/ideal_pulse_gen.sv
// ---------------------------------------------------------------------------
// ideal_pulse_gen
// Timestamp-driven pulse generator. Requests are queued in a small FIFO,
// popped one at a time, compared against the shared {utc, coarse} timebase
// and, on an exact match, turned into a pulse of the requested length. The
// fine-delay part of the popped request is presented to the delay line.
//
// Ports:
//   clk_ref_i     : reference clock
//   rst_i         : asynchronous, active-high reset
//   enable_i      : channel enable; low flushes the queue and idles the FSM
//   cntr_utc_i    : timebase seconds
//   cntr_coarse_i : timebase coarse count, 0..g_coarse_range-1
//   req           : request channel (slave side)
//   pulse_o       : output pulse, one cycle after the timebase match
//   delay_frac_o  : fine setting of the current/armed event
//   done_p1_o     : strobe in the last pulse cycle
//   missed_p1_o   : strobe when an armed request is late or invalid
//   count_o       : FIFO occupancy
// ---------------------------------------------------------------------------
module ideal_pulse_gen #(
    parameter int unsigned g_queue_depth  = 4,
    parameter int unsigned g_coarse_range = 125000000
) (
    input  logic                             clk_ref_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic [31:0]                      cntr_utc_i,
    input  logic [27:0]                      cntr_coarse_i,
    ideal_pulse_gen_if.slave                 req,
    output logic                             pulse_o,
    output logic [22:0]                      delay_frac_o,
    output logic                             done_p1_o,
    output logic                             missed_p1_o,
    output logic [$clog2(g_queue_depth):0]   count_o
);

    localparam int unsigned       PTR_W        = $clog2(g_queue_depth);
    localparam int unsigned       CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH        = CNT_W'(g_queue_depth);
    localparam logic [27:0]       COARSE_RANGE = 28'(g_coarse_range);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;

    typedef struct packed {
        logic [31:0] utc;
        logic [27:0] coarse;
        logic [22:0] frac;
        logic [27:0] width;
    } req_t;

    // Request FIFO
    req_t             fifo_mem [g_queue_depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    req_t             head;

    // Event FSM
    logic [1:0]  state_q, state_d;
    logic [31:0] tgt_utc_q, tgt_utc_d;
    logic [27:0] tgt_coarse_q, tgt_coarse_d;
    logic [27:0] width_q, width_d;
    logic [27:0] cnt_q, cnt_d;
    logic [22:0] frac_q, frac_d;
    logic        pulse_q, pulse_d;
    logic        done_q, done_d;
    logic        missed;
    logic [59:0] target;
    logic [59:0] now;

    // Ready is withheld on the full cycle, so a pop on a full FIFO can never
    // coincide with a push; the slot it frees is offered on the next cycle.
    assign req.ready = enable_i && !rst_i && (count_q < DEPTH);
    assign push      = req.valid && req.ready;
    assign pop       = enable_i && (state_q == S_IDLE) && (count_q != '0);
    assign head      = fifo_mem[rd_ptr_q];

    // {utc, coarse} compares correctly as one unsigned number because coarse
    // wraps to 0 exactly when utc increments.
    assign target = {tgt_utc_q, tgt_coarse_q};
    assign now    = {cntr_utc_i, cntr_coarse_i};

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!enable_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        tgt_utc_d    = tgt_utc_q;
        tgt_coarse_d = tgt_coarse_q;
        width_d      = width_q;
        cnt_d        = cnt_q;
        frac_d       = frac_q;
        missed       = 1'b0;
        if (!enable_i) begin
            // Aborted events leave silently: no done/missed strobe.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tgt_utc_d    = head.utc;
                        tgt_coarse_d = head.coarse;
                        width_d      = head.width;
                        frac_d       = head.frac;
                        state_d      = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (tgt_coarse_q >= COARSE_RANGE || target < now) begin
                        missed  = 1'b1;
                        state_d = S_IDLE;
                    end else if (target == now) begin
                        cnt_d   = (width_q == '0) ? '0 : width_q - 28'd1;
                        state_d = S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 28'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Outputs are registered from the next state so the pulse and the
        // done strobe come straight off flops.
        pulse_d = (state_d == S_PULSE);
        done_d  = (state_d == S_PULSE) && (cnt_d == '0);
    end

    always_ff @(posedge clk_ref_i or posedge rst_i) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            tgt_utc_q    <= '0;
            tgt_coarse_q <= '0;
            width_q      <= '0;
            cnt_q        <= '0;
            frac_q       <= '0;
            pulse_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            tgt_utc_q    <= tgt_utc_d;
            tgt_coarse_q <= tgt_coarse_d;
            width_q      <= width_d;
            cnt_q        <= cnt_d;
            frac_q       <= frac_d;
            pulse_q      <= pulse_d;
            done_q       <= done_d;
        end
    end

    // NOTE: the storage array is not reset; occupancy is tracked by the reset
    // pointers and count, so stale entries are never read.
    always_ff @(posedge clk_ref_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{utc: req.utc, coarse: req.coarse,
                                    frac: req.frac, width: req.width};
        end
    end

    assign pulse_o      = pulse_q;
    assign done_p1_o    = done_q;
    assign missed_p1_o  = missed;
    assign delay_frac_o = frac_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_ideal_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_ideal_pulse_gen
// Directed scenarios followed by a randomized phase. An event-level reference
// model decides, at each pop, the whole fate of the request (miss cycle or
// pulse window) from absolute timebase arithmetic; outputs are compared every
// cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_ideal_pulse_gen;

    localparam int     DEPTH = 4;
    localparam longint R     = 125000000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] cntr_utc;
    logic [27:0] cntr_coarse;
    logic        pulse;
    logic [22:0] frac_o;
    logic        done;
    logic        missed;
    logic [2:0]  count;

    ideal_pulse_gen_if req_if ();

    ideal_pulse_gen #(
        .g_queue_depth  (DEPTH),
        .g_coarse_range (125000000)
    ) dut (
        .clk_ref_i     (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .cntr_utc_i    (cntr_utc),
        .cntr_coarse_i (cntr_coarse),
        .req           (req_if),
        .pulse_o       (pulse),
        .delay_frac_o  (frac_o),
        .done_p1_o     (done),
        .missed_p1_o   (missed),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        longint      abs_t;
        logic [27:0] coarse;
        logic [22:0] frac;
        int          width;
    } mreq_t;

    mreq_t       mq[$];
    longint      cyc;
    longint      cur_abs;
    longint      free_at;
    longint      ev_ps, ev_pe, ev_done, ev_missed;
    logic [22:0] m_frac;
    bit          last_push;
    int          obs_pulse, obs_done, obs_missed, n_accepted;
    int          n_tests, n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_tb();
        cntr_utc    = 32'(cur_abs / R);
        cntr_coarse = 28'(cur_abs % R);
    endtask

    task automatic model_clear();
        mq.delete();
        ev_ps     = 0;
        ev_pe     = -1;
        ev_done   = -1;
        ev_missed = -1;
        free_at   = cyc;
        m_frac    = '0;
    endtask

    // Fate of a request popped in cycle k: armed in k+1 against timebase
    // cur_abs+1; the timebase then advances one tick per cycle.
    task automatic schedule(input mreq_t r);
        longint a, t_arm, m;
        int     w;
        a     = cyc + 1;
        t_arm = cur_abs + 1;
        if (longint'(r.coarse) >= R || r.abs_t < t_arm) begin
            ev_missed = a;
            ev_ps     = 0;
            ev_pe     = -1;
            ev_done   = -1;
            free_at   = a + 1;
        end else begin
            m         = a + (r.abs_t - t_arm);
            w         = (r.width < 1) ? 1 : r.width;
            ev_ps     = m + 1;
            ev_pe     = m + w;
            ev_done   = ev_pe;
            ev_missed = -1;
            free_at   = ev_pe + 1;
        end
    endtask

    task automatic model_cycle();
        bit    e_ready;
        mreq_t r;
        if (!enable) begin
            if (ev_missed >= cyc) ev_missed = -1;
            if (ev_done > cyc)    ev_done   = -1;
            if (ev_pe > cyc)      ev_pe     = cyc;
        end
        e_ready = enable && (mq.size() < DEPTH);
        check("pulse_o",      64'(pulse),        64'(cyc >= ev_ps && cyc <= ev_pe));
        check("done_p1_o",    64'(done),         64'(cyc == ev_done));
        check("missed_p1_o",  64'(missed),       64'(cyc == ev_missed));
        check("count_o",      64'(count),        64'(mq.size()));
        check("req_ready_o",  64'(req_if.ready), 64'(e_ready));
        check("delay_frac_o", 64'(frac_o),       64'(m_frac));
        if (pulse)  obs_pulse++;
        if (done)   obs_done++;
        if (missed) obs_missed++;
        last_push = req_if.valid && e_ready;
        if (last_push) n_accepted++;
        if (!enable) begin
            mq.delete();
            free_at = cyc + 1;
        end else begin
            if (free_at <= cyc && mq.size() != 0) begin
                r      = mq.pop_front();
                m_frac = r.frac;
                schedule(r);
            end
            if (last_push) begin
                r.abs_t  = longint'(req_if.utc) * R + longint'(req_if.coarse);
                r.coarse = req_if.coarse;
                r.frac   = req_if.frac;
                r.width  = int'(req_if.width);
                mq.push_back(r);
            end
        end
    endtask

    // One clock cycle: evaluate/check on the falling edge, then advance the
    // timebase just after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        cyc++;
        #1;
        cur_abs++;
        drive_tb();
    endtask

    task automatic set_req(input longint utc, input longint coarse, input int frac, input int width);
        req_if.utc    = 32'(utc);
        req_if.coarse = 28'(coarse);
        req_if.frac   = 23'(frac);
        req_if.width  = 28'(width);
    endtask

    task automatic push_req(input longint utc, input longint coarse, input int frac, input int width);
        int n;
        set_req(utc, coarse, frac, width);
        req_if.valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_push && n < 64);
        req_if.valid = 1'b0;
        if (!last_push) check("push_accept", 64'(last_push), 64'd1);
    endtask

    task automatic push_abs(input longint t, input int frac, input int width);
        push_req(t / R, t % R, frac, width);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(mq.size() == 0 && free_at <= cyc) && n < 2000) begin
            tick();
            n++;
        end
        if (!(mq.size() == 0 && free_at <= cyc)) check("wait_idle", 64'(mq.size()), 64'd0);
    endtask

    task automatic jump_to(input longint t);
        wait_idle();
        cur_abs = t;
        drive_tb();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_obs();
        obs_pulse  = 0;
        obs_done   = 0;
        obs_missed = 0;
        n_accepted = 0;
    endtask

    initial begin
        longint t0;
        int     n;
        n_tests      = 0;
        n_fail       = 0;
        cyc          = 0;
        rst          = 1'b1;
        enable       = 1'b1;
        req_if.valid = 1'b0;
        set_req(0, 0, 0, 0);
        cur_abs = 5 * R + 900;
        drive_tb();
        model_clear();
        clear_obs();

        // Reset values (enable high, so ready is held low only by reset)
        @(posedge clk);
        #1;
        check("rst_pulse",  64'(pulse),        64'd0);
        check("rst_done",   64'(done),         64'd0);
        check("rst_missed", 64'(missed),       64'd0);
        check("rst_frac",   64'(frac_o),       64'd0);
        check("rst_count",  64'(count),        64'd0);
        check("rst_ready",  64'(req_if.ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();

        // Single event
        jump_to(5 * R + 1000);
        clear_obs();
        push_req(5, 1010, 'h1234, 3);
        wait_idle();
        run(3);
        check("single_pulses", 64'(obs_pulse),  64'd3);
        check("single_done",   64'(obs_done),   64'd1);
        check("single_missed", 64'(obs_missed), 64'd0);
        check("single_frac",   64'(frac_o),     64'h1234);

        // Coarse wrap, then an event that matches right after the first one
        jump_to(7 * R + 124999990);
        clear_obs();
        push_req(7, 124999999, 'h00aa, 4);
        push_req(8, 5, 'h0bb, 2);
        wait_idle();
        run(3);
        check("wrap_pulses", 64'(obs_pulse),  64'd6);
        check("wrap_done",   64'(obs_done),   64'd2);
        check("wrap_missed", 64'(obs_missed), 64'd0);

        // Late, invalid and blocked events
        jump_to(5 * R);
        clear_obs();
        push_req(3, 0, 'h11, 1);
        push_req(5, R, 'h22, 1);
        wait_idle();
        t0 = cur_abs + 12;
        push_abs(t0, 'h33, 10);
        push_abs(t0 + 2, 'h44, 1);
        wait_idle();
        run(3);
        check("late_missed", 64'(obs_missed), 64'd3);
        check("late_pulses", 64'(obs_pulse),  64'd10);
        check("late_done",   64'(obs_done),   64'd1);

        // FIFO full with far-future requests
        clear_obs();
        set_req(cur_abs / R, cur_abs % R + 50000, 'h55, 1);
        req_if.valid = 1'b1;
        run(8);
        req_if.valid = 1'b0;
        check("full_count",    64'(count),        64'd4);
        check("full_ready",    64'(req_if.ready), 64'd0);
        check("full_accepted", 64'(n_accepted),   64'd5);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        check("flush_count", 64'(count), 64'd0);
        run(2);

        // Width 0 and back-to-back events
        clear_obs();
        t0 = cur_abs + 12;
        push_abs(t0, 'h66, 0);
        push_abs(t0 + 3, 'h77, 1);
        wait_idle();
        run(3);
        check("b2b_pulses", 64'(obs_pulse), 64'd2);
        check("b2b_done",   64'(obs_done),  64'd2);

        // Disable on the 2nd cycle of a 5-cycle pulse
        clear_obs();
        t0 = cyc;
        push_abs(cur_abs + 8, 'h88, 5);
        n = 0;
        while (!(ev_ps > t0 && cyc == ev_ps + 1) && n < 60) begin
            tick();
            n++;
        end
        check("dis_reached", 64'(cyc == ev_ps + 1), 64'd1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        check("dis_pulse_low", 64'(pulse), 64'd0);
        check("dis_count",     64'(count), 64'd0);
        run(4);
        check("dis_pulses", 64'(obs_pulse),  64'd2);
        check("dis_done",   64'(obs_done),   64'd0);
        check("dis_missed", 64'(obs_missed), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            longint tgt;
            enable       = ($urandom_range(99) >= 4);
            req_if.valid = ($urandom_range(99) < 35);
            tgt          = cur_abs + longint'($urandom_range(45)) - 5;
            if ($urandom_range(15) == 0)
                set_req(cur_abs / R, R + longint'($urandom_range(7)), int'($urandom), int'($urandom_range(6)));
            else
                set_req(tgt / R, tgt % R, int'($urandom), int'($urandom_range(6)));
            tick();
        end
        enable       = 1'b1;
        req_if.valid = 1'b0;
        wait_idle();
        run(3);

        // Asynchronous reset in the middle of a pulse
        t0 = cyc;
        push_abs(cur_abs + 6, 'h99, 8);
        n = 0;
        while (!(ev_ps > t0 && cyc == ev_ps + 2) && n < 60) begin
            tick();
            n++;
        end
        check("pre_rst_pulse", 64'(pulse), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pulse",  64'(pulse),        64'd0);
        check("arst_done",   64'(done),         64'd0);
        check("arst_missed", 64'(missed),       64'd0);
        check("arst_frac",   64'(frac_o),       64'd0);
        check("arst_count",  64'(count),        64'd0);
        check("arst_ready",  64'(req_if.ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        run(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
